// File: rtl/branch_predict_tournament.sv
// branch_predict_tournament
//   Tournament branch predictor. A local two-level predictor (BHT + local PHT)
//   and a gshare predictor run side by side, and a per-PC chooser picks which
//   one drives the fetch prediction. The tables are read combinationally in F
//   from pcF. They are trained in M from the indices and component predictions
//   that the datapath carries down the pipe.
//
//   Ports
//     clk, rst           clock; synchronous active-low reset
//     predict_mode       0 local, 1 gshare, 2 tournament, 3 static not-taken
//     pcF                fetch PC
//     *F outputs         prediction and the indices/component predictions the
//                        pipeline must carry to M
//     branchM ... *M     resolved branch and its carried F-stage state
//     branch_cnt         committed branches (saturating)
//     mispredict_cnt     committed mispredictions (saturating)

// Bank of 2-bit saturating counters. There is one combinational read port and
// one write port. All entries reset to weakly-not-taken (2'b01).
module bpt_ctr_table #(
  parameter int IDX_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic                rd_msb,
  input  logic                upd,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                up
);
  localparam int N = 1 << IDX_BITS;

  logic [1:0] tbl [N];

  assign rd_msb = tbl[rd_idx][1];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) tbl[i] <= 2'b01;
    end else if (upd) begin
      if (up && tbl[upd_idx] != 2'b11)
        tbl[upd_idx] <= tbl[upd_idx] + 2'd1;
      else if (!up && tbl[upd_idx] != 2'b00)
        tbl[upd_idx] <= tbl[upd_idx] - 2'd1;
    end
  end
endmodule

module branch_predict_tournament #(
  parameter int PC_HASH_BITS    = 3,
  parameter int PHT_INDEX_BITS  = 7,
  parameter int GHR_BITS        = 8,
  parameter int CPHT_INDEX_BITS = 8,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 predict_mode,
  input  logic [31:0]                pcF,
  output logic                       predict_takeF,
  output logic [PC_HASH_BITS-1:0]    pc_hashingF,
  output logic [PHT_INDEX_BITS-1:0]  PHT_indexF,
  output logic [GHR_BITS-1:0]        gPHT_indexF,
  output logic [CPHT_INDEX_BITS-1:0] cpht_indexF,
  output logic                       local_predF,
  output logic                       global_predF,
  input  logic                       branchM,
  input  logic                       actually_takenM,
  input  logic                       predict_resultM,
  input  logic [PC_HASH_BITS-1:0]    BHT_indexM,
  input  logic [PHT_INDEX_BITS-1:0]  PHT_indexM,
  input  logic [GHR_BITS-1:0]        gPHT_indexM,
  input  logic [CPHT_INDEX_BITS-1:0] cpht_indexM,
  input  logic                       local_predM,
  input  logic                       global_predM,
  output logic [CNT_WIDTH-1:0]       branch_cnt,
  output logic [CNT_WIDTH-1:0]       mispredict_cnt
);
  localparam int BHT_N = 1 << PC_HASH_BITS;

  logic [PHT_INDEX_BITS-1:0] bht [BHT_N];
  logic [GHR_BITS-1:0]       ghr;
  logic                      choose_global;
  logic                      unused_pc;

  // Only a low slice of pcF feeds the indices. The parameters decide which
  // bits are used, so the whole bus is folded here to keep lint quiet.
  assign unused_pc = ^pcF;

  // F-stage index generation
  assign pc_hashingF = pcF[PC_HASH_BITS+1:2];
  assign PHT_indexF  = bht[pc_hashingF];
  assign gPHT_indexF = pcF[GHR_BITS+1:2] ^ ghr;
  assign cpht_indexF = pcF[CPHT_INDEX_BITS+1:2];

  bpt_ctr_table #(.IDX_BITS(PHT_INDEX_BITS)) u_lpht (
    .clk(clk), .rst(rst), .rd_idx(PHT_indexF), .rd_msb(local_predF),
    .upd(branchM), .upd_idx(PHT_indexM), .up(actually_takenM)
  );

  bpt_ctr_table #(.IDX_BITS(GHR_BITS)) u_gpht (
    .clk(clk), .rst(rst), .rd_idx(gPHT_indexF), .rd_msb(global_predF),
    .upd(branchM), .upd_idx(gPHT_indexM), .up(actually_takenM)
  );

  // The chooser trains only when the components disagreed. It moves toward
  // gshare (MSB set) when gshare was the one that got it right.
  bpt_ctr_table #(.IDX_BITS(CPHT_INDEX_BITS)) u_cpht (
    .clk(clk), .rst(rst), .rd_idx(cpht_indexF), .rd_msb(choose_global),
    .upd(branchM && (local_predM != global_predM)), .upd_idx(cpht_indexM),
    .up(global_predM == actually_takenM)
  );

  always_comb begin
    predict_takeF = 1'b0;
    case (predict_mode)
      2'd0: predict_takeF = local_predF;
      2'd1: predict_takeF = global_predF;
      2'd2: predict_takeF = choose_global ? global_predF : local_predF;
      default: predict_takeF = 1'b0;
    endcase
  end

  // The local histories and the GHR are updated only from resolved outcomes.
  // Nothing in them is speculative, so there is nothing to repair on a flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= '0;
      ghr <= '0;
    end else if (branchM) begin
      bht[BHT_indexM] <= {bht[BHT_indexM][PHT_INDEX_BITS-2:0], actually_takenM};
      ghr             <= {ghr[GHR_BITS-2:0], actually_takenM};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (branchM) begin
      if (branch_cnt != '1)
        branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      if ((predict_resultM != actually_takenM) && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
    end
  end
endmodule
